// File: rtl/ysyx_24100006_uart_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : ysyx_24100006_uart_fifo                                           |
// | Brief   : AXI-Lite UART TX device; transmit FIFO drained one byte per DIV   |
// |           cycles onto a valid/ready byte stream.                            |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module ysyx_24100006_uart_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'ha000_03f0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd1,
  parameter bit          SIM_PRINT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int                c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [31:2]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp, r_bresp;
  logic                r_en, r_ie, r_ovf, r_irq;
  logic [15:0]         r_div, r_cnt;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wptr, r_rptr;
  logic [c_ptr_w:0]    r_count;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;

  logic        w_in_win, w_wr_ctrl, w_wr_status, w_wr_data;
  logic        w_full, w_empty, w_push, w_drop, w_pop, w_flush;
  logic [7:0]  w_byte;
  logic [15:0] w_div_eff;
  logic [31:0] w_rdata_nxt;
  logic [1:0]  w_rresp_nxt, w_bresp_nxt;
  logic        w_unused;

  assign w_unused = ^{axi_araddr[1:0], axi_awaddr[1:0]};

  assign w_in_win    = (r_addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_ctrl   = (r_state == S_WADDR) && w_in_win && (r_addr[3:2] == 2'd0);
  assign w_wr_status = (r_state == S_WADDR) && w_in_win && (r_addr[3:2] == 2'd1);
  assign w_wr_data   = (r_state == S_WADDR) && w_in_win && (r_addr[3:2] == 2'd2);

  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign w_push    = w_wr_data && (|r_wstrb) && !w_full;
  assign w_drop    = w_wr_data && (|r_wstrb) && w_full;
  assign w_flush   = w_wr_ctrl && r_wstrb[0] && r_wdata[2];
  assign w_pop     = r_en && !w_empty && !r_tx_valid && (r_cnt == 16'd0) && !w_flush;
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;

  always_comb begin
    w_byte = r_wdata[7:0];
    if (r_wstrb[0])      w_byte = r_wdata[7:0];
    else if (r_wstrb[1]) w_byte = r_wdata[15:8];
    else if (r_wstrb[2]) w_byte = r_wdata[23:16];
    else                 w_byte = r_wdata[31:24];
  end

  // Read mux; DATA is write-only and answers SLVERR, reserved/outside answers DECERR
  always_comb begin
    w_rdata_nxt = 32'h0;
    w_rresp_nxt = 2'b11;
    if (w_in_win) begin
      case (r_addr[3:2])
        2'd0: begin
          w_rdata_nxt = {r_div, 14'h0, r_ie, r_en};
          w_rresp_nxt = 2'b00;
        end
        2'd1: begin
          w_rdata_nxt = {16'h0, 8'(r_count), 4'h0, r_tx_valid, r_ovf, w_empty, w_full};
          w_rresp_nxt = 2'b00;
        end
        2'd2:    w_rresp_nxt = 2'b10;
        default: w_rresp_nxt = 2'b11;
      endcase
    end
  end

  always_comb begin
    w_bresp_nxt = 2'b00;
    if (!w_in_win || (r_addr[3:2] == 2'd3)) w_bresp_nxt = 2'b11;
    else if (w_drop)                        w_bresp_nxt = 2'b10;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (axi_arvalid)                     w_state_nxt = S_RADDR;
        else if (axi_awvalid && axi_wvalid)  w_state_nxt = S_WADDR;
      end
      S_RADDR: w_state_nxt = S_RDATA;
      S_RDATA: if (axi_rready) w_state_nxt = S_IDLE;
      S_WADDR: w_state_nxt = S_WRESP;
      S_WRESP: if (axi_bready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
      r_bresp <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (axi_arvalid) begin
          r_addr <= axi_araddr[31:2];
        end else if (axi_awvalid && axi_wvalid) begin
          r_addr  <= axi_awaddr[31:2];
          r_wdata <= axi_wdata;
          r_wstrb <= axi_wstrb;
        end
      end
      if (r_state == S_RADDR) begin
        r_rdata <= w_rdata_nxt;
        r_rresp <= w_rresp_nxt;
      end
      if (r_state == S_WADDR) r_bresp <= w_bresp_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en  <= 1'b1;
      r_ie  <= 1'b0;
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        if (r_wstrb[0]) {r_ie, r_en} <= r_wdata[1:0];
        if (r_wstrb[2]) r_div[7:0]   <= r_wdata[23:16];
        if (r_wstrb[3]) r_div[15:8]  <= r_wdata[31:24];
      end
      if (w_drop)                          r_ovf <= 1'b1;
      else if (w_wr_status && r_wdata[2])  r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_byte;
  end

  // Fullness is judged on the pre-edge count, so a pop never makes room for a same-edge push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_cnt      <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_tx_data  <= r_mem[r_rptr];
        r_tx_valid <= 1'b1;
        r_cnt      <= w_div_eff - 16'd1;
      end else begin
        if (r_tx_valid && tx_ready) r_tx_valid <= 1'b0;
        if (r_cnt != 16'd0)         r_cnt      <= r_cnt - 16'd1;
      end
      r_irq <= r_ie && w_empty && !r_tx_valid;
    end
  end

  assign axi_arready = (r_state == S_RADDR);
  assign axi_rvalid  = (r_state == S_RDATA);
  assign axi_rdata   = r_rdata;
  assign axi_rresp   = r_rresp;
  assign axi_awready = (r_state == S_WADDR);
  assign axi_wready  = (r_state == S_WADDR);
  assign axi_bvalid  = (r_state == S_WRESP);
  assign axi_bresp   = r_bresp;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign irq         = r_irq;

  if (SIM_PRINT) begin : g_sim_print
    always_ff @(posedge clk) begin
      if (r_tx_valid && tx_ready) $write("%c", r_tx_data);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_uart_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_ysyx_24100006_uart_fifo                                        |
// | Brief   : Directed self-checking bench with a byte-queue scoreboard.        |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_ysyx_24100006_uart_fifo;

  localparam logic [31:0] c_ctrl   = 32'ha000_03f0;
  localparam logic [31:0] c_status = 32'ha000_03f4;
  localparam logic [31:0] c_data   = 32'ha000_03f8;
  localparam logic [31:0] c_resv   = 32'ha000_03fc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        irq;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   model_ie = 1'b0;
  logic [7:0] exp_q[$];
  int         hs_cyc[$];
  logic [7:0] hs_dat[$];
  bit         r_held = 1'b0;
  logic [7:0] r_held_data = '0;

  ysyx_24100006_uart_fifo #(
    .BASE_ADDR (32'ha000_03f0),
    .FIFO_DEPTH(16),
    .DIV_RESET (16'd1),
    .SIM_PRINT (1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-stream scoreboard: every accepted byte must leave exactly once, in order, held stable
  always @(negedge clk) begin
    if (!reset_n) begin
      r_held <= 1'b0;
    end else begin
      if (r_held && tx_valid) chk("tx_hold_stable", {24'h0, tx_data}, {24'h0, r_held_data});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", {24'h0, tx_data}, 32'hffff_ffff);
        end else begin
          chk("tx_order", {24'h0, tx_data}, {24'h0, exp_q[0]});
          void'(exp_q.pop_front());
        end
        hs_cyc.push_back(cyc);
        hs_dat.push_back(tx_data);
      end
      r_held      <= tx_valid && !tx_ready;
      r_held_data <= tx_data;
      if (!model_ie) chk("irq_ie0", {31'h0, irq}, 32'h0);
    end
  end

  // Entered and left just after a rising edge; runs read and/or write channels concurrently
  task automatic xfer(input bit do_rd, input logic [31:0] ra,
                      input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws,
                      output logic [31:0] rd, output logic [1:0] rr,
                      output logic [1:0] br, output int first);
    bit rd_done, wr_done, got_ar, got_aw;
    rd = '0; rr = '0; br = '0; first = 0;
    rd_done = !do_rd; wr_done = !do_wr; got_ar = 0; got_aw = 0;
    axi_araddr = ra; axi_arvalid = do_rd;
    axi_awaddr = wa; axi_wdata = wd; axi_wstrb = ws;
    axi_awvalid = do_wr; axi_wvalid = do_wr;
    axi_rready = 1'b1; axi_bready = 1'b1;
    for (int c = 0; c < 40 && !(rd_done && wr_done); c++) begin
      @(negedge clk);
      if (axi_arready && !got_ar) begin got_ar = 1; if (first == 0) first = 1; end
      if (axi_awready && !got_aw) begin got_aw = 1; if (first == 0) first = 2; end
      if (axi_rvalid && !rd_done) begin rd = axi_rdata; rr = axi_rresp; rd_done = 1; end
      if (axi_bvalid && !wr_done) begin br = axi_bresp; wr_done = 1; end
      @(posedge clk); #1;
      if (got_ar) axi_arvalid = 1'b0;
      if (got_aw) begin axi_awvalid = 1'b0; axi_wvalid = 1'b0; end
    end
    axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_rready = 1'b0; axi_bready = 1'b0;
    if (!(rd_done && wr_done)) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_reg(input string name, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d; logic [1:0] r, b; int f;
    xfer(1'b1, a, 1'b0, '0, '0, '0, d, r, b, f);
    chk({name, "_rdata"}, d, exp_d);
    chk({name, "_rresp"}, {30'h0, r}, {30'h0, exp_r});
  endtask

  task automatic wr_reg(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [1:0] exp_b);
    logic [31:0] d; logic [1:0] r, b; int f;
    xfer(1'b0, '0, 1'b1, a, wd, ws, d, r, b, f);
    chk({name, "_bresp"}, {30'h0, b}, {30'h0, exp_b});
  endtask

  task automatic push(input logic [7:0] byt, input logic [1:0] exp_b);
    if (exp_b == 2'b00) exp_q.push_back(byt);
    wr_reg("push", c_data, {24'h0, byt}, 4'b0001, exp_b);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d; logic [1:0] r, b; int f;
    bit aw_seen;

    repeat (3) @(negedge clk);
    chk("reset_outs", {axi_arready, axi_rvalid, axi_awready, axi_wready, axi_bvalid, tx_valid, irq},
        32'h0);
    chk("reset_data", {tx_data, axi_rresp, axi_bresp}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset register values
    rd_reg("t1_status", c_status, 32'h0000_0002, 2'b00);
    rd_reg("t1_ctrl",   c_ctrl,   32'h0001_0001, 2'b00);

    // 2: paced drain at DIV=4
    wr_reg("t2_div", c_ctrl, 32'h0004_0001, 4'b1111, 2'b00);
    hs_cyc.delete(); hs_dat.delete();
    push(8'h41, 2'b00);
    push(8'h42, 2'b00);
    wait_drain();
    chk("t2_hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) begin
      chk("t2_gap", hs_cyc[1] - hs_cyc[0], 4);
      chk("t2_byte0", {24'h0, hs_dat[0]}, 32'h41);
      chk("t2_byte1", {24'h0, hs_dat[1]}, 32'h42);
    end

    // 3: fill with draining stopped, overflow the 17th push
    wr_reg("t3_en0", c_ctrl, 32'h0000_0000, 4'b0001, 2'b00);
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i), (i < 16) ? 2'b00 : 2'b10);
    rd_reg("t3_status", c_status, 32'h0000_1005, 2'b00);

    // 4: clear OVF, flush, error responses, interrupt
    wr_reg("t4_ovfclr", c_status, 32'h0000_0004, 4'b0001, 2'b00);
    rd_reg("t4_status_a", c_status, 32'h0000_1001, 2'b00);
    wr_reg("t4_flush", c_ctrl, 32'h0000_0004, 4'b0001, 2'b00);
    exp_q.delete();
    rd_reg("t4_status_b", c_status, 32'h0000_0002, 2'b00);
    chk("t4_no_txvalid", {31'h0, tx_valid}, 32'h0);
    rd_reg("t4_data_rd", c_data, 32'h0, 2'b10);
    rd_reg("t4_resv_rd", c_resv, 32'h0, 2'b11);
    rd_reg("t4_out_rd", 32'ha000_0400, 32'h0, 2'b11);
    wr_reg("t4_resv_wr", c_resv, 32'h0000_00ff, 4'b1111, 2'b11);
    wr_reg("t4_nostrb", c_data, 32'h0000_0055, 4'b0000, 2'b00);
    rd_reg("t4_status_c", c_status, 32'h0000_0002, 2'b00);
    model_ie = 1'b1;
    wr_reg("t4_ie_on", c_ctrl, 32'h0000_0002, 4'b0001, 2'b00);
    @(negedge clk);
    chk("t4_irq", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    wr_reg("t4_ie_off", c_ctrl, 32'h0000_0001, 4'b0001, 2'b00);
    model_ie = 1'b0;

    // 5: backpressure, lane select, then drain
    tx_ready = 1'b0;
    push(8'h31, 2'b00);
    push(8'h32, 2'b00);
    exp_q.push_back(8'h33);
    wr_reg("t5_lane2", c_data, 32'h0033_0000, 4'b0100, 2'b00);
    repeat (8) @(posedge clk);
    #1;
    rd_reg("t5_status", c_status, 32'h0000_0208, 2'b00);
    chk("t5_held_byte", {31'h0, tx_valid, tx_data}, 32'h131);
    tx_ready = 1'b1;
    wait_drain();

    xfer(1'b1, c_status, 1'b1, c_data, 32'h0000_005a, 4'b0001, d, r, b, f);
    exp_q.push_back(8'h5a);
    chk("t5_order_first", f, 1);
    chk("t5_rd_status", d, 32'h0000_0002);
    chk("t5_wr_bresp", {30'h0, b}, 32'h0);
    wait_drain();

    // 6: asynchronous reset while a write response and a byte are pending
    tx_ready = 1'b0;
    push(8'h71, 2'b00);
    push(8'h72, 2'b00);
    axi_awaddr = c_data; axi_wdata = 32'h73; axi_wstrb = 4'b0001;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b0;
    aw_seen = 1'b0;
    for (int c = 0; c < 20 && !axi_bvalid; c++) begin
      @(negedge clk);
      if (axi_awready) aw_seen = 1'b1;
      if (!axi_bvalid) begin
        @(posedge clk); #1;
        if (aw_seen) begin axi_awvalid = 1'b0; axi_wvalid = 1'b0; end
      end
    end
    chk("t6_pre_busy", {30'h0, axi_bvalid, tx_valid}, 32'h3);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_outs", {axi_arready, axi_rvalid, axi_awready, axi_wready, axi_bvalid, tx_valid, irq},
        32'h0);
    chk("t6_rst_data", {tx_data, axi_rresp, axi_bresp}, 32'h0);
    chk("t6_rst_rdata", axi_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rd_reg("t6_status", c_status, 32'h0000_0002, 2'b00);
    rd_reg("t6_ctrl",   c_ctrl,   32'h0001_0001, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_tx", {31'h0, tx_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
